// File: rtl/multiplicador_sequencial_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
// Product width is twice the operand width; the step counter indexes operand bits.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/multiplicador_sequencial_if.sv
// Operand/product handshake bundle of the sequential multiplier.
// Handshake: a transfer happens on the rising edge where valid and ready are both 1;
// the sender holds its data stable while valid is high and ready is low, and
// neither ready nor valid depends combinationally on the other side's signal.
interface multiplicador_sequencial_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/multiplicador_sequencial_produto_parcial.sv
// One partial-product row: the multiplicand gated by a single multiplier bit.
module produto_parcial_param #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  output logic [WIDTH-1:0] pp
);

  assign pp = a & {WIDTH{sel}};

endmodule

// File: rtl/multiplicador_sequencial.sv
// Sequential unsigned multiplier: one partial product accumulated per clock,
// fixed WIDTH-cycle latency, result held in its own register until replaced.
module multiplicador_sequencial
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  multiplicador_sequencial_if.slave        bus,
  output state_t                           state_dbg
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product_reg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             consume;
  logic             last_step;

  produto_parcial_param #(.WIDTH(WIDTH)) u_row (
    .a   (a_reg),
    .sel (b_reg[cnt]),
    .pp  (pp)
  );

  // Ready/valid come straight from the registered state, so there is no
  // combinational path from in_valid or out_ready back to them.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = product_reg;
  assign state_dbg     = state_q;

  assign accept    = bus.in_valid  && (state_q == IDLE);
  assign consume   = bus.out_ready && (state_q == DONE);
  assign last_step = (state_q == CALC) && (cnt == CNT_LAST);
  assign acc_next  = acc + ({{WIDTH{1'b0}}, pp} << cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (consume)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        acc   <= '0;
        cnt   <= '0;
      end else if (state_q == CALC) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        // The published product only changes when a full result is ready.
        if (last_step) begin
          product_reg <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed and model-checked bench for the sequential multiplier at WIDTH 4 and 8.
module tb_multiplicador_sequencial;
  import multiplicador_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg4;
  state_t state_dbg8;
  int     n_checks;
  int     n_fail;
  logic [15:0] exp_q[$];

  multiplicador_sequencial_if #(.WIDTH(4)) bus4 ();
  multiplicador_sequencial_if #(.WIDTH(8)) bus8 ();

  multiplicador_sequencial #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4.slave),
    .state_dbg (state_dbg4)
  );

  multiplicador_sequencial #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8.slave),
    .state_dbg (state_dbg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called at a falling edge while the DUT is idle; return at the
  // falling edge just after the accepting rising edge.
  task automatic present4(input logic [3:0] a, input logic [3:0] b);
    bus4.in_valid = 1'b1;
    bus4.a = a;
    bus4.b = b;
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  task automatic present8(input logic [7:0] a, input logic [7:0] b);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0;
    #12;
    n_checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.product !== 8'd0 || state_dbg4 !== IDLE) begin
      n_fail++;
      $display("FAIL reset_w4: in_ready=%b out_valid=%b product=%0d state=%0d, required 1 0 0 0",
               bus4.in_ready, bus4.out_valid, bus4.product, state_dbg4);
    end
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.product !== 16'd0 || state_dbg8 !== IDLE) begin
      n_fail++;
      $display("FAIL reset_w8: in_ready=%b out_valid=%b product=%0d state=%0d, required 1 0 0 0",
               bus8.in_ready, bus8.out_valid, bus8.product, state_dbg8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus4.out_ready = 1'b1;
    present4(4'd9, 4'd6);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b0 || state_dbg4 !== CALC) begin
        n_fail++;
        $display("FAIL basic_calc_%0d: in_ready=%b out_valid=%b state=%0d, required 0 0 %0d",
                 i, bus4.in_ready, bus4.out_valid, state_dbg4, CALC);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus4.out_valid !== 1'b1 || bus4.product !== 8'd54) begin
      n_fail++;
      $display("FAIL basic_done: out_valid=%b product=%0d, required 1 54", bus4.out_valid, bus4.product);
    end
    @(negedge clk);
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.product !== 8'd54) begin
      n_fail++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b product=%0d, required 0 1 54",
               bus4.out_valid, bus4.in_ready, bus4.product);
    end
  endtask

  task automatic test_max_zero();
    int lat;
    bus4.out_ready = 1'b1;
    present4(4'd15, 4'd15);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd225) begin
      n_fail++;
      $display("FAIL max_operands: latency=%0d product=%0d, required 4 225", lat, bus4.product);
    end
    @(negedge clk);
    present4(4'd0, 4'd13);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_operand: latency=%0d product=%0d, required 4 0", lat, bus4.product);
    end
    @(negedge clk);
    present4(4'd13, 4'd1);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd13) begin
      n_fail++;
      $display("FAIL lsb_only: latency=%0d product=%0d, required 4 13", lat, bus4.product);
    end
    @(negedge clk);
    present4(4'd5, 4'd8);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd40) begin
      n_fail++;
      $display("FAIL msb_only: latency=%0d product=%0d, required 4 40", lat, bus4.product);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    bus4.out_ready = 1'b0;
    present4(4'd7, 4'd3);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: latency=%0d, required 4", lat);
    end
    bus4.in_valid = 1'b1;
    bus4.a = 4'd2;
    bus4.b = 4'd2;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus4.out_valid !== 1'b1 || bus4.product !== 8'd21 || bus4.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b product=%0d in_ready=%b, required 1 21 0",
                 i, bus4.out_valid, bus4.product, bus4.in_ready);
      end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.product !== 8'd21 || state_dbg4 !== IDLE) begin
      n_fail++;
      $display("FAIL bp_consume: out_valid=%b in_ready=%b product=%0d state=%0d, required 0 1 21 0",
               bus4.out_valid, bus4.in_ready, bus4.product, state_dbg4);
    end
    @(negedge clk);
    n_checks++;
    if (state_dbg4 !== IDLE) begin
      n_fail++;
      $display("FAIL bp_no_queue: state=%0d, required 0", state_dbg4);
    end
    present4(4'd2, 4'd2);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd4) begin
      n_fail++;
      $display("FAIL bp_represent: latency=%0d product=%0d, required 4 4", lat, bus4.product);
    end
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int lat;
    bus4.out_ready = 1'b1;
    present4(4'd11, 4'd5);
    bus4.a = 4'd3;
    bus4.b = 4'd1;
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd55) begin
      n_fail++;
      $display("FAIL operand_change: latency=%0d product=%0d, required 4 55", lat, bus4.product);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bus4.out_ready = 1'b1;
    present4(4'd9, 4'd6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.product !== 8'd0 || bus4.in_ready !== 1'b1 || state_dbg4 !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_calc: out_valid=%b product=%0d in_ready=%b state=%0d, required 0 0 1 0",
               bus4.out_valid, bus4.product, bus4.in_ready, state_dbg4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    present4(4'd3, 4'd4);
    wait_out4(lat);
    n_checks++;
    if (lat !== 4 || bus4.product !== 8'd12) begin
      n_fail++;
      $display("FAIL after_reset_op: latency=%0d product=%0d, required 4 12", lat, bus4.product);
    end
    @(negedge clk);
  endtask

  task automatic test_width8();
    int lat;
    bus8.out_ready = 1'b1;
    present8(8'd255, 8'd255);
    wait_out8(lat);
    n_checks++;
    if (lat !== 8 || bus8.product !== 16'd65025) begin
      n_fail++;
      $display("FAIL w8_max: latency=%0d product=%0d, required 8 65025", lat, bus8.product);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    int stall;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      bus8.out_ready = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      present8(a, b);
      exp_q.push_back(16'(a) * 16'(b));
      wait_out8(lat);
      n_checks++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL rand_latency_%0d: latency=%0d, required 8", n, lat);
      end
      for (int s = 0; s < stall; s++) begin
        n_checks++;
        if (bus8.out_valid !== 1'b1 || bus8.product !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_stall_%0d: out_valid=%b product=%0d, required 1 %0d",
                   n, bus8.out_valid, bus8.product, exp_q[0]);
        end
        @(negedge clk);
      end
      bus8.out_ready = 1'b1;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus8.out_valid !== 1'b1 || bus8.product !== exp) begin
        n_fail++;
        $display("FAIL rand_product_%0d: %0d*%0d out_valid=%b product=%0d, required 1 %0d",
                 n, a, b, bus8.out_valid, bus8.product, exp);
      end
      @(negedge clk);
      n_checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_release_%0d: out_valid=%b in_ready=%b, required 0 1",
                 n, bus8.out_valid, bus8.in_ready);
      end
    end
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_max_zero();
    test_backpressure();
    test_operand_change();
    test_reset_mid_calc();
    test_width8();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
